// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: latches a WIDTH-bit pattern plus repeat count and
// shifts it out MSB-first. Optional even-parity bit per repetition via SEQ_TX_PARITY_EN.
module seq_pattern_tx #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: a load transfers on a rising edge where load_valid && load_ready;
    // load_ready is high only while the FSM sits in IDLE or DONE.

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef SEQ_TX_PARITY_EN
        PAR   = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pat_q, pat_n;
    logic [CNT_W-1:0] rep_q, rep_n;
    logic [BIT_W-1:0] bit_q, bit_n;
    logic             dout_n, dout_valid_n, load_ready_n, busy_n, done_n;
    logic             accept;

    assign accept    = load_valid && load_ready;
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        rep_n   = rep_q;
        bit_n   = bit_q;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_n = SHIFT;
                    pat_n   = pattern;
                    rep_n   = repeat_cnt;
                    bit_n   = LAST_BIT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (bit_q != '0) begin
                    bit_n = bit_q - 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_n = PAR;
`else
                    // Rep counter stops at zero, so repeat_cnt = all-ones never wraps.
                    if (rep_q != '0) begin
                        rep_n = rep_q - 1'b1;
                        bit_n = LAST_BIT;
                    end else begin
                        state_n = DONE;
                    end
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                if (rep_q != '0) begin
                    state_n = SHIFT;
                    rep_n   = rep_q - 1'b1;
                    bit_n   = LAST_BIT;
                end else begin
                    state_n = DONE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values, so they describe the
    // state the FSM is in during the following cycle.
    always_comb begin
        dout_n       = 1'b0;
        dout_valid_n = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        load_ready_n = 1'b0;
        case (state_n)
            SHIFT: begin
                dout_n       = pat_n[bit_n];
                dout_valid_n = 1'b1;
                busy_n       = 1'b1;
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                dout_n       = ^pat_n;
                dout_valid_n = 1'b1;
                busy_n       = 1'b1;
            end
`endif
            DONE: begin
                done_n       = 1'b1;
                load_ready_n = 1'b1;
            end
            default: load_ready_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pat_q      <= '0;
            rep_q      <= '0;
            bit_q      <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pat_q      <= pat_n;
            rep_q      <= rep_n;
            bit_q      <= bit_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            load_ready <= load_ready_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed table, corner sequences and
// random loads checked against a bit-stream model built from the pattern rules.
module tb_seq_pattern_tx;

    localparam int WIDTH = 3;
    localparam int CNT_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int BPR = WIDTH + 1;
`else
    localparam int BPR = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic             dout, dout_valid, busy, done;
    logic [1:0]       state_dbg;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .dout(dout),
        .dout_valid(dout_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] pat;
        logic [CNT_W-1:0] rep;
        int               exp_len;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream: every repetition is the pattern MSB-first, plus parity if enabled.
    task automatic model(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
        exp_q.delete();
        for (int r = 0; r <= int'(rep); r++) begin
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(pat[i]);
`ifdef SEQ_TX_PARITY_EN
            exp_q.push_back(^pat);
`endif
        end
    endtask

    // Drive a load at the negedge; returns #1 after the accepting edge (sample 1).
    task automatic start_load(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
        @(negedge clk);
        load_valid = 1'b1;
        pattern    = pat;
        repeat_cnt = rep;
        chk("load_ready_before_load", load_ready, 1'b1);
        model(pat, rep);
        @(posedge clk);
        #1;
    endtask

    // Consume the stream until done; inputs are scrambled to prove they are latched.
    task automatic stream_check(input int noise_at, output int nvalid);
        int k;
        int exp_len;
        exp_len = exp_q.size();
        nvalid  = 0;
        k       = 1;
        chk("first_bit_valid", dout_valid, 1'b1);
        chk("busy_first", busy, 1'b1);
        chk("load_ready_low_busy", load_ready, 1'b0);
        forever begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_valid_bit", 1'b1, 1'b0);
                end else begin
                    chk("dout_bit", dout, exp_q.pop_front());
                end
                nvalid++;
            end else if (!done) begin
                chk("gap_in_stream", dout_valid, 1'b1);
            end
            if (done) begin
                chk("done_cycle", k, exp_len + 1);
                chk("bits_seen", nvalid, exp_len);
                chk("done_dout_zero", dout, 1'b0);
                chk("done_load_ready", load_ready, 1'b1);
                chk("done_not_busy", busy, 1'b0);
                break;
            end
            if (k > 300) begin
                chk("done_timeout", 1'b0, 1'b1);
                break;
            end
            @(negedge clk);
            load_valid = (k == noise_at);
            pattern    = (k == noise_at) ? 3'b001 : WIDTH'($urandom);
            repeat_cnt = CNT_W'($urandom);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done_low", done, 1'b0);
        chk("idle_valid_low", dout_valid, 1'b0);
        chk("idle_load_ready", load_ready, 1'b1);
        chk("idle_not_busy", busy, 1'b0);
    endtask

    vec_t vecs[6];
    int   nv;

    initial begin
        vecs[0] = '{pat: 3'b101, rep: 4'd0,  exp_len: BPR * 1};
        vecs[1] = '{pat: 3'b101, rep: 4'd1,  exp_len: BPR * 2};
        vecs[2] = '{pat: 3'b100, rep: 4'd1,  exp_len: BPR * 2};
        vecs[3] = '{pat: 3'b011, rep: 4'd2,  exp_len: BPR * 3};
        vecs[4] = '{pat: 3'b000, rep: 4'd0,  exp_len: BPR * 1};
        vecs[5] = '{pat: 3'b111, rep: 4'd15, exp_len: BPR * 16};

        // Asynchronous reset asserted mid-cycle.
        #12;
        rst = 1'b0;
        #1;
        chk("rst_dout", dout, 1'b0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_load(vecs[i].pat, vecs[i].rep);
            stream_check(0, nv);
            chk("table_len", nv, vecs[i].exp_len);
            check_idle();
        end

        // Long stream with an ignored mid-stream load, then a load held through DONE.
        start_load(3'b110, 4'd15);
        stream_check(10, nv);
        chk("long_len", nv, BPR * 16);
        start_load(3'b101, 4'd0);
        stream_check(0, nv);
        check_idle();

        // Reset in the middle of a stream aborts it with no done pulse.
        start_load(3'b111, 4'd3);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("pre_abort_valid", dout_valid, 1'b1);
        end
        #3;
        rst = 1'b0;
        #1;
        chk("abort_dout", dout, 1'b0);
        chk("abort_dout_valid", dout_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_load_ready", load_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        start_load(3'b101, 4'd0);
        stream_check(0, nv);
        check_idle();

        // Random loads, sometimes chained straight through DONE.
        for (int it = 0; it < 25; it++) begin
            start_load(WIDTH'($urandom_range(0, 7)), CNT_W'($urandom_range(0, 3)));
            stream_check(0, nv);
            if ($urandom_range(0, 1) == 0) begin
                check_idle();
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    @(posedge clk);
                    #1;
                    chk("gap_idle_valid", dout_valid, 1'b0);
                end
            end
        end
        check_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
